cd_tx_ram_reader: RTL and testbench



---
 rtl/cd_pkg.sv | 17 +
 rtl/cd_skid2.sv | 61 ++++++
 rtl/cd_tx_ram_reader.sv | 165 ++++++++++++++++
 tb/tb_cd_tx_ram_reader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cd_pkg.sv
// cd_pkg: constants and shared types for the CDBUS TX RAM reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Frame layout in RAM: src, dst, len, then len payload bytes.
package cd_pkg;

  localparam int CD_HDR_LEN = 3;    // src + dst + len
  localparam int CD_LEN_OFS = 2;    // position of the len byte in the frame
  localparam int CD_MAX_LEN = 253;  // largest legal len byte

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_FETCH = 2'd1,
    RD_DRAIN = 2'd2
  } cd_rd_state_e;

endpackage

// File: rtl/cd_skid2.sv
// cd_skid2: two-entry byte FIFO that decouples the SRAM read pipe from the serializer.
// Latency: a push is visible at the head on the following clock.
// Backpressure: the caller keeps occupancy <= 2; a push into a full FIFO is only taken together with a pop.
// Ports: push/push_dat write side, pop read side, head_dat/head_vld current head, count = entries held,
//        flush empties the FIFO on the next edge (stored bytes are discarded, not cleared).
module cd_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         head_vld,
  output logic [1:0]   count
);

  logic [W-1:0] mem_q [2];
  logic         wr_q;
  logic         rd_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (cnt_q != 2'd0);
  assign do_push = push && ((cnt_q != 2'd2) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_dat;
        wr_q        <= ~wr_q;
      end
      if (do_pop) begin
        rd_q <= ~rd_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign head_dat = mem_q[rd_q];
  assign head_vld = (cnt_q != 2'd0);
  assign count    = cnt_q;

endmodule

// File: rtl/cd_tx_ram_reader.sv
// cd_tx_ram_reader: streams one stored CDBUS frame (src, dst, len, payload) from the TX SRAM to the serializer.
// Latency: first out_valid two edges after the edge that takes start, then one byte per clock while out_ready is high.
// Backpressure: bytes held + read in flight never exceed two; ram_re stays low until a pop frees room.
// Ports: start/start_addr/abort control; busy, done, len_err status; ram_ra/ram_re/ram_rd SRAM read port
//        (data one clock after re); out_data/out_valid/out_ready byte stream to cd_tx_ser.
module cd_tx_ram_reader
  import cd_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int MAX_LEN = CD_MAX_LEN
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [A_WIDTH-1:0] start_addr,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               len_err,
  output logic [A_WIDTH-1:0] ram_ra,
  output logic               ram_re,
  input  logic [7:0]         ram_rd,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CW = A_WIDTH + 1;

  cd_rd_state_e       state_q, state_d;
  logic [A_WIDTH-1:0] ptr_q;
  logic [CW-1:0]      issued_q;
  logic [CW-1:0]      sent_q;
  logic [CW-1:0]      total_q;
  logic               inflight_q;
  logic [1:0]         hdr_cnt_q;   // bytes written to the buffer so far, saturating at 3
  logic               done_q;
  logic               done_d;

  logic [1:0]         buf_cnt;
  logic               buf_vld;
  logic [7:0]         buf_dat;

  logic               accept;
  logic               pop;
  logic               push;
  logic               cap;
  logic [7:0]         len_clamped;
  logic [CW-1:0]      total_cap;
  logic [CW-1:0]      total_eff;
  logic [2:0]         occ;
  logic               room;
  logic               last_pop;

  assign accept = (state_q == RD_IDLE) && start && !abort;
  assign pop    = buf_vld && out_ready;
  assign push   = inflight_q;

  // The len byte is the third byte to land in the buffer.
  assign cap         = push && (hdr_cnt_q == 2'(CD_LEN_OFS));
  assign len_clamped = (ram_rd > 8'(MAX_LEN)) ? 8'(MAX_LEN) : ram_rd;
  assign total_cap   = CW'(CD_HDR_LEN) + CW'(len_clamped);
  assign len_err     = cap && (ram_rd > 8'(MAX_LEN));

  // The 4th read can be issued in the very cycle len arrives, so the issue
  // limit must already use the freshly computed total (covers len = 0).
  assign total_eff = cap ? total_cap : total_q;

  // A pop this cycle frees a slot now; counting it keeps the pipe full at
  // one byte per clock while still never holding more than two bytes.
  assign occ  = {1'b0, buf_cnt} + {2'b00, inflight_q};
  assign room = occ < (3'd2 + {2'b00, pop});

  assign ram_re = (state_q == RD_FETCH) && room && (issued_q < total_eff);
  assign ram_ra = ptr_q;

  assign last_pop = pop && ((sent_q + CW'(1)) == total_q);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (accept) state_d = RD_FETCH;
      end
      RD_FETCH: begin
        // The final byte can leave before the drain state is reached.
        if (last_pop) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end else if ((issued_q == total_q) && !inflight_q) begin
          state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        if (last_pop) begin
          state_d = RD_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
    if (abort) begin
      state_d = RD_IDLE;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RD_IDLE;
      ptr_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      total_q    <= '0;
      inflight_q <= 1'b0;
      hdr_cnt_q  <= 2'd0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      done_q     <= done_d;
      inflight_q <= ram_re && !abort;
      if (accept) begin
        ptr_q     <= start_addr;
        issued_q  <= '0;
        sent_q    <= '0;
        // Provisional total until len is read: large enough to let the header through.
        total_q   <= {1'b1, {A_WIDTH{1'b0}}};
        hdr_cnt_q <= 2'd0;
      end else begin
        if (ram_re) begin
          ptr_q    <= ptr_q + A_WIDTH'(1);
          issued_q <= issued_q + CW'(1);
        end
        if (pop) begin
          sent_q <= sent_q + CW'(1);
        end
        if (cap) begin
          total_q <= total_cap;
        end
        if (push && (hdr_cnt_q != 2'd3)) begin
          hdr_cnt_q <= hdr_cnt_q + 2'd1;
        end
      end
    end
  end

  cd_skid2 #(.W(8)) u_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (abort),
    .push     (push),
    .push_dat (ram_rd),
    .pop      (pop),
    .head_dat (buf_dat),
    .head_vld (buf_vld),
    .count    (buf_cnt)
  );

  assign busy      = (state_q != RD_IDLE);
  assign done      = done_q;
  assign out_valid = buf_vld;
  assign out_data  = buf_dat;

endmodule

// File: tb/tb_cd_tx_ram_reader.sv
// Bench for cd_tx_ram_reader: table of frames plus hand-written abort and reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_cd_tx_ram_reader;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] len;
    int         mode;       // 0: ready high, 1: ready 1,0,0,1 repeating, 2: random
    int         exp_total;
    logic       exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] start_addr = 8'h00;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic       len_err;
  logic [7:0] ram_ra;
  logic       ram_re;
  logic [7:0] ram_rd = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;

  always #5 clk = ~clk;

  cd_tx_ram_reader #(.A_WIDTH(8), .MAX_LEN(253)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .len_err    (len_err),
    .ram_ra     (ram_ra),
    .ram_re     (ram_re),
    .ram_rd     (ram_rd),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Synchronous-read SRAM model.
  logic [7:0] mem [256];
  always @(posedge clk) if (ram_re) ram_rd <= mem[ram_ra];

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] exp_q [$];
  logic [7:0] ra_log [$];
  int         pop_cnt, iss_cnt, max_out, len_err_cnt, done_cnt;
  int         first_vld_cyc, first_pop_cyc, last_pop_cyc, done_cyc, start_edge;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  vec_t       tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sample();
    if (!reset_n) begin
      prev_hold = 1'b0;
      return;
    end
    if (ram_re) begin
      ra_log.push_back(ram_ra);
      iss_cnt++;
    end
    if (prev_hold && out_valid) chk("hold_stable", out_data, prev_dat);
    if (out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(exp_q.size()), 1);
      else chk($sformatf("byte%0d", pop_cnt), out_data, exp_q.pop_front());
      if (pop_cnt == 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
      pop_cnt++;
    end
    if (iss_cnt - pop_cnt > max_out) max_out = iss_cnt - pop_cnt;
    if (len_err) len_err_cnt++;
    if (done) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    prev_hold = out_valid && !out_ready;
    prev_dat  = out_data;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_counters();
    pop_cnt = 0; iss_cnt = 0; max_out = 0; len_err_cnt = 0; done_cnt = 0;
    first_vld_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
  endtask

  task automatic set_ready(input int mode, input int k);
    case (mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((k % 4) == 0) || ((k % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  // src=01, dst=02, len, payload AA, BB, CC, ... (253 payload bytes, fills all 256 locations)
  task automatic load_frame(input logic [7:0] a, input logic [7:0] len);
    logic [7:0] p;
    mem[a] = 8'h01;
    p = a + 8'd1; mem[p] = 8'h02;
    p = a + 8'd2; mem[p] = len;
    for (int i = 0; i < 253; i++) begin
      p = a + 8'(3 + i);
      mem[p] = 8'hAA + 8'(8'h11 * i);
    end
  endtask

  task automatic run_frame(input int r);
    vec_t       v;
    logic [7:0] p;
    int         ra_bad;
    v = tbl[r];
    load_frame(v.addr, v.len);
    clear_counters();
    exp_q.delete();
    ra_log.delete();
    for (int i = 0; i < v.exp_total; i++) begin
      p = v.addr + 8'(i);
      exp_q.push_back(mem[p]);
    end
    start_addr = v.addr;
    start = 1'b1;
    set_ready(v.mode, 0);
    tick();
    start = 1'b0;
    start_edge = cyc;
    for (int k = 1; k < 3000 && done_cnt == 0; k++) begin
      set_ready(v.mode, k);
      tick();
    end
    out_ready = 1'b1;
    tick();
    tick();
    chk($sformatf("row%0d_done_count", r), done_cnt, 1);
    chk($sformatf("row%0d_bytes_out", r), pop_cnt, v.exp_total);
    chk($sformatf("row%0d_bytes_left", r), exp_q.size(), 0);
    chk($sformatf("row%0d_len_err", r), len_err_cnt, 32'(v.exp_err));
    chk($sformatf("row%0d_busy_end", r), busy, 0);
    chk($sformatf("row%0d_outstanding", r), (max_out <= 2), 1);
    chk($sformatf("row%0d_first_valid", r), first_vld_cyc - start_edge, 2);
    chk($sformatf("row%0d_done_after_last", r), done_cyc - last_pop_cyc, 1);
    if (v.mode == 0)
      chk($sformatf("row%0d_back_to_back", r), last_pop_cyc - first_pop_cyc, v.exp_total - 1);
    ra_bad = 0;
    for (int i = 0; i < ra_log.size(); i++) begin
      p = v.addr + 8'(i);
      if (ra_log[i] !== p) ra_bad++;
    end
    chk($sformatf("row%0d_ra_count", r), ra_log.size(), v.exp_total);
    chk($sformatf("row%0d_ra_seq", r), ra_bad, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p;
    tbl[0] = '{8'h10, 8'h03, 0, 6,   1'b0};
    tbl[1] = '{8'h10, 8'h03, 1, 6,   1'b0};
    tbl[2] = '{8'hFE, 8'h02, 0, 5,   1'b0};
    tbl[3] = '{8'h40, 8'hFF, 0, 256, 1'b1};
    tbl[4] = '{8'h80, 8'h00, 2, 3,   1'b0};
    tbl[5] = '{8'h20, 8'hFE, 1, 256, 1'b1};
    tbl[6] = '{8'h30, 8'hFD, 0, 256, 1'b0};
    clear_counters();

    // Reset state
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_ram_re", ram_re, 0);
    chk("rst_ram_ra", ram_ra, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    reset_n = 1'b1;
    tick();

    for (int r = 0; r < 7; r++) run_frame(r);

    // Abort after the 4th byte
    load_frame(8'h10, 8'h03);
    clear_counters();
    exp_q.delete();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'hAA, 8'hBB, 8'hCC};
    start_addr = 8'h10;
    start = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 50 && pop_cnt < 4; k++) tick();
    chk("abort_reached_4", (pop_cnt >= 4), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ram_re", ram_re, 0);
    p = pop_cnt;
    repeat (5) tick();
    chk("abort_no_more_bytes", pop_cnt, p);
    chk("abort_no_done", done_cnt, 0);
    exp_q.delete();

    // abort and start together: abort wins
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("abort_start_busy", busy, 0);
    tick();
    chk("abort_start_valid", out_valid, 0);
    run_frame(0);

    // Reset during FETCH with two bytes buffered
    load_frame(8'h10, 8'h03);
    clear_counters();
    exp_q.delete();
    start_addr = 8'h10;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_head", out_data, 8'h01);
    chk("bp_ram_re", ram_re, 0);
    chk("bp_reads_issued", iss_cnt, 2);
    chk("bp_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_ram_re", ram_re, 0);
    chk("mid_rst_ram_ra", ram_ra, 0);
    chk("mid_rst_done", done, 0);
    tick();
    reset_n = 1'b1;
    tick();
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
